des_subkey_gen: RTL and testbench

- Iterative DES key schedule that streams the 16 48-bit round subkeys, one per accepted transfer.
- Encrypt mode emits K1..K16 using left rotations. Decrypt mode emits K16..K1 using right rotations, so the round datapath needs no subkey storage.
- Sits beside the S-box/round logic and feeds each 3DES stage; `decrypt` selects the direction per stage (E-D-E).

---
 rtl/des_subkey_gen.sv | 197 +++++++++++++++++++
 tb/tb_des_subkey_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/des_subkey_gen.sv
// Iterative DES key schedule: streams the 16 round subkeys, K1..K16 for
// encryption (left rotations) or K16..K1 for decryption (right rotations).
module des_subkey_gen (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FIPS 46-3 bit numbers (1 = MSB) selected by each output position, MSB first.
  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(7'd64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'd56 - PC2_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    if (two) begin
      return {x[25:0], x[27:26]};
    end else begin
      return {x[26:0], x[27]};
    end
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    if (two) begin
      return {x[1:0], x[27:2]};
    end else begin
      return {x[0], x[27:1]};
    end
  endfunction

  state_t      state_r, state_n;
  logic [27:0] c_r, c_n, d_r, d_n;
  logic [3:0]  cnt_r, cnt_n;
  logic [3:0]  idx_r, idx_n;
  logic        dec_r, dec_n;
  logic        valid_r, valid_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;
  logic [55:0] key_pc1_s;
  logic        xfer_s;
  logic        rot_two_s;

  assign key_pc1_s = pc1(key_in);
  assign xfer_s    = valid_r & subkey_ready;
  // Single-bit rotations fall before rounds 2, 9 and 16 in either direction.
  assign rot_two_s = !((cnt_r == 4'd0) || (cnt_r == 4'd7) || (cnt_r == 4'd14));

  // Next-state, datapath and output decode.
  always_comb begin
    state_n = state_r;
    c_n     = c_r;
    d_n     = d_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    dec_n   = dec_r;
    valid_n = valid_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          dec_n   = decrypt;
          cnt_n   = 4'd0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
          if (decrypt) begin
            c_n   = key_pc1_s[55:28];
            d_n   = key_pc1_s[27:0];
            idx_n = 4'd15;
          end else begin
            c_n   = rotl(key_pc1_s[55:28], 1'b0);
            d_n   = rotl(key_pc1_s[27:0], 1'b0);
            idx_n = 4'd0;
          end
        end else begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end
      end
      RUN: begin
        if (xfer_s) begin
          if (cnt_r == 4'd15) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            cnt_n = cnt_r + 4'd1;
            if (dec_r) begin
              c_n   = rotr(c_r, rot_two_s);
              d_n   = rotr(d_r, rot_two_s);
              idx_n = idx_r - 4'd1;
            end else begin
              c_n   = rotl(c_r, rot_two_s);
              d_n   = rotl(d_r, rot_two_s);
              idx_n = idx_r + 4'd1;
            end
          end
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, key halves and registered status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      c_r     <= 28'd0;
      d_r     <= 28'd0;
      cnt_r   <= 4'd0;
      idx_r   <= 4'd0;
      dec_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      c_r     <= c_n;
      d_r     <= d_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      dec_r   <= dec_n;
      valid_r <= valid_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  assign subkey       = pc2({c_r, d_r});
  assign subkey_valid = valid_r;
  assign round_idx    = idx_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Directed bench for des_subkey_gen using the FIPS worked-example key schedule.
module tb_des_subkey_gen;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;

  logic [47:0] exp_keys [16];

  localparam logic [63:0] KEY_A   = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KEY_B   = 64'h0E32_9232_EA6D_0D73;
  localparam logic [63:0] KEY_ZP  = 64'h0101_0101_0101_0101;
  localparam logic [63:0] PAR_MSK = 64'h0101_0101_0101_0101;

  des_subkey_gen dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one full schedule; zero_key expects all-zero subkeys.
  task automatic run_sched(input logic [63:0] key, input logic dec, input bit rnd_ready,
                           input bit inject_start, input bit zero_key);
    int          k;
    int          cyc;
    int          idx;
    logic        rdy;
    logic        xfer;
    logic [47:0] exp_sk;
    @(negedge clk);
    start        = 1'b1;
    key_in       = key;
    decrypt      = dec;
    subkey_ready = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (inject_start && k == 3) begin
        start   = 1'b1;
        key_in  = KEY_B;
        decrypt = ~dec;
      end else begin
        start = 1'b0;
      end
      idx    = dec ? 15 - k : k;
      exp_sk = zero_key ? 48'd0 : exp_keys[idx];
      check("valid", 64'(subkey_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("subkey", 64'(subkey), 64'(exp_sk));
      check("round_idx", 64'(round_idx), 64'(idx));
      rdy          = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      subkey_ready = rdy;
      xfer         = subkey_valid & rdy;
      @(posedge clk);
      if (xfer) k++;
    end
    check("transfers", 64'(k), 64'd16);
    if (!rnd_ready) check("throughput_cycles", 64'(cyc), 64'd16);
    @(negedge clk);
    subkey_ready = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("valid_after", 64'(subkey_valid), 64'd0);
    check("busy_in_done", 64'(busy), 64'd0);
    // A start in the DONE cycle must be dropped.
    start   = 1'b1;
    key_in  = key;
    decrypt = dec;
    @(negedge clk);
    start = 1'b0;
    check("done_clear", 64'(done), 64'd0);
    check("start_in_done_ignored", 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_keys[0]  = 48'h1B02EFFC7072;
    exp_keys[1]  = 48'h79AED9DBC9E5;
    exp_keys[2]  = 48'h55FC8A42CF99;
    exp_keys[3]  = 48'h72ADD6DB351D;
    exp_keys[4]  = 48'h7CEC07EB53A8;
    exp_keys[5]  = 48'h63A53E507B2F;
    exp_keys[6]  = 48'hEC84B7F618BC;
    exp_keys[7]  = 48'hF78A3AC13BFB;
    exp_keys[8]  = 48'hE0DBEBEDE781;
    exp_keys[9]  = 48'hB1F347BA464F;
    exp_keys[10] = 48'h215FD3DED386;
    exp_keys[11] = 48'h7571F59467E9;
    exp_keys[12] = 48'h97C5D1FABA41;
    exp_keys[13] = 48'h5F43B7F2E73A;
    exp_keys[14] = 48'hBF918D3D3F0A;
    exp_keys[15] = 48'hCB3D8B0E17F5;

    n_rst        = 1'b0;
    start        = 1'b0;
    key_in       = 64'd0;
    decrypt      = 1'b0;
    subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    run_sched(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sched(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sched(KEY_A, 1'b0, 1'b1, 1'b0, 1'b0);
    run_sched(KEY_A, 1'b1, 1'b1, 1'b0, 1'b0);
    run_sched(KEY_A, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after the 5th transfer aborts the schedule at once.
    @(negedge clk);
    start        = 1'b1;
    key_in       = KEY_A;
    decrypt      = 1'b0;
    subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("abort_valid", 64'(subkey_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_round_idx", 64'(round_idx), 64'd0);
    repeat (2) @(negedge clk);
    n_rst        = 1'b1;
    subkey_ready = 1'b0;
    @(negedge clk);
    check("post_abort_idle", 64'(subkey_valid), 64'd0);
    run_sched(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0);

    run_sched(KEY_ZP, 1'b0, 1'b0, 1'b0, 1'b1);
    run_sched(KEY_ZP, 1'b1, 1'b0, 1'b0, 1'b1);
    run_sched(KEY_A ^ PAR_MSK, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sched(KEY_A ^ PAR_MSK, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
